// File: rtl/iomem_gpio.sv
// iomem_gpio: memory-mapped GPIO peripheral on a valid/ready iomem bus.
// Holds output, output-enable and interrupt configuration registers.
// Synchronizes the pin inputs and raises a level interrupt on enabled
// rising or falling edges.
//
// Register index = iomem_addr[4:2]
//   0 OUT      rw
//   1 OE       rw
//   2 IN       ro  (synchronized pins)
//   3 IRQ_EN   rw
//   4 IRQ_POL  rw  (0 rising, 1 falling)
//   5 IRQ_STAT w1c
//   6 OUT_SET  wo  (reads 0)
//   7 OUT_CLR  wo  (reads 0)
module iomem_gpio #(
  parameter int          WIDTH       = 16,
  parameter logic [7:0]  BASE_ADDR   = 8'h03,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  localparam logic [2:0] IDX_OUT  = 3'd0;
  localparam logic [2:0] IDX_OE   = 3'd1;
  localparam logic [2:0] IDX_IN   = 3'd2;
  localparam logic [2:0] IDX_EN   = 3'd3;
  localparam logic [2:0] IDX_POL  = 3'd4;
  localparam logic [2:0] IDX_STAT = 3'd5;
  localparam logic [2:0] IDX_SET  = 3'd6;
  localparam logic [2:0] IDX_CLR  = 3'd7;

  logic [WIDTH-1:0]             r_out;
  logic [WIDTH-1:0]             r_oe;
  logic [WIDTH-1:0]             r_en;
  logic [WIDTH-1:0]             r_pol;
  logic [WIDTH-1:0]             r_stat;
  logic [SYNC_STAGES*WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]             r_prev;

  logic                         w_sel;
  logic                         w_wr_en;
  logic [2:0]                   w_idx;
  logic [31:0]                  w_bmask32;
  logic [WIDTH-1:0]             w_m;
  logic [WIDTH-1:0]             w_wd_m;
  logic [WIDTH-1:0]             w_sync;
  logic [WIDTH-1:0]             w_evt;
  logic [WIDTH-1:0]             w_clr;
  logic [WIDTH-1:0]             w_rd;
  logic                         w_unused;

  // A request is only taken while ready is low, so transfers are spaced
  // at least two cycles apart and a held valid is never double-counted.
  assign w_sel     = iomem_valid & ~iomem_ready & (iomem_addr[31:24] == BASE_ADDR);
  assign w_wr_en   = w_sel & (|iomem_wstrb);
  assign w_idx     = iomem_addr[4:2];
  assign w_bmask32 = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  // Lanes above WIDTH simply do not exist, so their data and strobes drop out here.
  assign w_m       = w_bmask32[WIDTH-1:0];
  assign w_wd_m    = iomem_wdata[WIDTH-1:0] & w_m;

  assign w_sync    = r_sync[SYNC_STAGES*WIDTH-1 -: WIDTH];
  // Edge in the selected direction: current differs from polarity, previous matched it.
  assign w_evt     = (w_sync ^ r_pol) & ~(r_prev ^ r_pol) & r_en;
  assign w_clr     = (w_wr_en && (w_idx == IDX_STAT)) ? w_wd_m : '0;

  assign gpio_out  = r_out;
  assign gpio_oe   = r_oe;
  // Purely from flops: enable masks immediately, status is untouched.
  assign irq       = |(r_stat & r_en);

  assign w_unused  = &{1'b0, iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, w_bmask32};

  // Read mux over current register contents (pre-write values).
  always_comb begin
    w_rd = '0;
    case (w_idx)
      IDX_OUT:  w_rd = r_out;
      IDX_OE:   w_rd = r_oe;
      IDX_IN:   w_rd = w_sync;
      IDX_EN:   w_rd = r_en;
      IDX_POL:  w_rd = r_pol;
      IDX_STAT: w_rd = r_stat;
      default:  w_rd = '0;
    endcase
  end

  // Bus handshake: one-cycle ready pulse with read data captured alongside it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= w_sel;
      iomem_rdata <= w_sel ? 32'(w_rd) : '0;
    end
  end

  // OUT register: byte-masked write plus atomic set/clear aliases.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out <= '0;
    end else if (w_wr_en) begin
      case (w_idx)
        IDX_OUT: r_out <= (r_out & ~w_m) | w_wd_m;
        IDX_SET: r_out <= r_out | w_wd_m;
        IDX_CLR: r_out <= r_out & ~w_wd_m;
        default: r_out <= r_out;
      endcase
    end
  end

  // Plain byte-masked configuration registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_oe  <= '0;
      r_en  <= '0;
      r_pol <= '0;
    end else if (w_wr_en) begin
      if (w_idx == IDX_OE)  r_oe  <= (r_oe  & ~w_m) | w_wd_m;
      if (w_idx == IDX_EN)  r_en  <= (r_en  & ~w_m) | w_wd_m;
      if (w_idx == IDX_POL) r_pol <= (r_pol & ~w_m) | w_wd_m;
    end
  end

  // Pin synchronizer chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[(SYNC_STAGES-1)*WIDTH-1:0], gpio_in};
      r_prev <= w_sync;
    end
  end

  // Interrupt status: new events override a simultaneous write-1-to-clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat <= '0;
    end else begin
      r_stat <= (r_stat & ~w_clr) | w_evt;
    end
  end

endmodule
